// File: rtl/regfile_dumper.sv
// regfile_dumper
//   Debug-side reader for the register file. A start pulse in IDLE walks every
//   register address, samples the regfile's combinational read port and streams
//   each word least-significant byte first over an 8-bit valid/ready interface
//   toward the debug UART TX FIFO.
//
// Ports
//   clk         clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_start     start request, only honoured in IDLE
//   o_busy      high in every state except IDLE
//   o_done      one-cycle pulse after the last byte is accepted
//   o_rf_addr   registered regfile read address
//   i_rf_data   regfile read data (combinational from o_rf_addr)
//   o_tx_data   byte to transmitter
//   o_tx_valid  byte valid
//   i_tx_ready  transmitter accepts on valid && ready at posedge
module regfile_dumper #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift;
    logic [BCW-1:0]        byte_cnt;

    // The outgoing byte is always the bottom of the shift register. After the
    // last byte of a word is sent the register has shifted out to zero, so
    // the byte output reads 0 whenever the streamer is idle.
    assign o_tx_data = shift[7:0];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            byte_cnt   <= '0;
            o_rf_addr  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        o_rf_addr <= '0;
                        o_busy    <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // Word is frozen here; later regfile writes do not affect it.
                    shift      <= i_rf_data;
                    byte_cnt   <= '0;
                    o_tx_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (o_tx_valid && i_tx_ready) begin
                        shift    <= shift >> 8;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            o_tx_valid <= 1'b0;
                            if (o_rf_addr == LAST_ADDR) begin
                                o_done <= 1'b1;
                                state  <= DONE;
                            end else begin
                                o_rf_addr <= o_rf_addr + 1'b1;
                                state     <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper
//   Directed bench for regfile_dumper: a default-size instance driven from a
//   table of dump scenarios, plus hand-written reset-abort and small-geometry
//   (ADDR_WIDTH=2, DATA_WIDTH=16) sequences.
module tb_regfile_dumper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, ready;
    logic        busy, done, txv;
    logic [4:0]  addr;
    logic [31:0] rdata;
    logic [7:0]  txd;
    logic [31:0] rf [32];
    assign rdata = rf[addr];

    regfile_dumper #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
        .o_rf_addr(addr), .i_rf_data(rdata), .o_tx_data(txd), .o_tx_valid(txv),
        .i_tx_ready(ready)
    );

    logic        start2, ready2, busy2, done2, txv2;
    logic [1:0]  addr2;
    logic [15:0] rdata2;
    logic [7:0]  txd2;
    logic [15:0] rf2 [4];
    assign rdata2 = rf2[addr2];

    regfile_dumper #(.ADDR_WIDTH(2), .DATA_WIDTH(16)) dut2 (
        .clk(clk), .i_rst_n(rst_n), .i_start(start2), .o_busy(busy2), .o_done(done2),
        .o_rf_addr(addr2), .i_rf_data(rdata2), .o_tx_data(txd2), .o_tx_valid(txv2),
        .i_tx_ready(ready2)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] got[$];
    logic [7:0] got2[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected dump content: x5 and x31 set, everything else zero.
    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = (i / 4 == 5) ? 32'hDEADBEEF : (i / 4 == 31) ? 32'h01234567 : 32'h0;
        return 8'(w >> (8 * (i % 4)));
    endfunction

    task automatic init_rf();
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[5]  = 32'hDEADBEEF;
        rf[31] = 32'h01234567;
    endtask

    // Byte collector plus hold check: a byte offered without ready must be
    // offered again, unchanged, on the next edge.
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h0;
    always @(posedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("hold_stable", {txv, txd}, {1'b1, hold_data});
            if (txv && ready) got.push_back(txd);
            hold_pend = txv && !ready;
            hold_data = txd;
            if (txv2 && ready2) got2.push_back(txd2);
        end
    end

    // One dump on the default instance. Cycle n is the period following
    // edge n-1, with edge 0 the one that samples start.
    task automatic run_dump(input int drop, input bit repulse, input bit wr_x5,
                            output int done_cyc, output int done_cnt,
                            output int first_v, output logic [4:0] addr_c1);
        done_cyc = -1; done_cnt = 0; first_v = -1; addr_c1 = '1;
        got.delete();
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) addr_c1 = addr;
            if (first_v < 0 && txv) first_v = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            ready = !(cyc >= 3 && cyc < 3 + drop);
            if (repulse && (cyc == 10 || done)) start = 1'b1;
            if (wr_x5 && cyc == 28) rf[5] = 32'hCAFEF00D;
            if (done_cyc > 0 && cyc == done_cyc + 1) chk("busy_after_done", busy, 0);
            if (done_cyc > 0 && cyc >= done_cyc + 4) break;
        end
        start = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_count"}, got.size(), 128);
        if (got.size() == 128) begin
            for (int i = 0; i < 128; i++) if (got[i] !== exp_byte(i)) bad++;
            chk({tag, "_stream"}, bad, 0);
            chk({tag, "_x5"}, {got[23], got[22], got[21], got[20]}, 32'hDEADBEEF);
            chk({tag, "_x31"}, {got[127], got[126], got[125], got[124]}, 32'h01234567);
        end
    endtask

    typedef struct {
        string name;
        int    drop;
        bit    repulse;
        bit    wr_x5;
        int    exp_done;
        int    exp_first_v;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int         done_cyc, done_cnt, first_v, waited;
        logic [4:0] addr_c1;
        logic [1:0] prev_a;
        bit         wrapped;
        int         bad, done2_cnt;
        logic [7:0] exp2 [8];

        vecs[0] = '{"basic",           0,  1'b0, 1'b0, 161, 2};
        vecs[1] = '{"stall",           10, 1'b0, 1'b0, 171, 2};
        vecs[2] = '{"start_ignored",   0,  1'b1, 1'b0, 161, 2};
        vecs[3] = '{"write_during",    0,  1'b0, 1'b1, 161, 2};

        init_rf();
        rf2[0] = 16'hA1B2; rf2[1] = 16'hC3D4; rf2[2] = 16'hE5F6; rf2[3] = 16'h0718;
        rst_n = 1'b0; start = 1'b0; ready = 1'b1; start2 = 1'b0; ready2 = 1'b0;
        #3;
        chk("reset_state", {busy, done, txv, txd, addr}, 0);
        chk("reset_state2", {busy2, done2, txv2, txd2, addr2}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            init_rf();
            run_dump(vecs[v].drop, vecs[v].repulse, vecs[v].wr_x5,
                     done_cyc, done_cnt, first_v, addr_c1);
            chk({vecs[v].name, "_addr_c1"}, addr_c1, 0);
            chk({vecs[v].name, "_first_valid"}, first_v, vecs[v].exp_first_v);
            chk({vecs[v].name, "_done_cycle"}, done_cyc, vecs[v].exp_done);
            chk({vecs[v].name, "_done_count"}, done_cnt, 1);
            check_stream(vecs[v].name);
            chk({vecs[v].name, "_idle"}, {busy, txv, addr}, {1'b0, 1'b0, 5'd31});
        end

        // Reset in the middle of a dump, between edges, after 50 bytes.
        init_rf();
        got.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (got.size() < 50 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_reached_50", got.size(), 50);
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_async_zero", {busy, done, txv, txd, addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_resume", {busy, txv}, 0);
        run_dump(0, 1'b0, 1'b0, done_cyc, done_cnt, first_v, addr_c1);
        chk("restart_addr_c1", addr_c1, 0);
        chk("restart_done_cycle", done_cyc, 161);
        check_stream("restart");

        // Small geometry with random backpressure.
        exp2 = '{8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hF6, 8'hE5, 8'h18, 8'h07};
        got2.delete();
        wrapped = 1'b0; done2_cnt = 0; done_cyc = -1; prev_a = 2'd0;
        @(negedge clk);
        start2 = 1'b1;
        ready2 = 1'($urandom_range(0, 1));
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            ready2 = 1'($urandom_range(0, 1));
            if (addr2 < prev_a) wrapped = 1'b1;
            prev_a = addr2;
            if (done2) begin
                done2_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
        end
        chk("p_done_seen", done_cyc > 0, 1);
        chk("p_done_count", done2_cnt, 1);
        chk("p_count", got2.size(), 8);
        if (got2.size() == 8) begin
            bad = 0;
            for (int i = 0; i < 8; i++) if (got2[i] !== exp2[i]) bad++;
            chk("p_stream", bad, 0);
        end
        chk("p_nowrap", wrapped, 0);
        chk("p_final", {busy2, txv2, addr2}, {1'b0, 1'b0, 2'd3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
